spi_master: RTL and testbench

SPI master that drives the slave-side shift interface used in our SPI blocks: generates `sclk`, shifts a parallel word out on `mosi` MSB-first, samples `miso` into a parallel word, and ends each frame with a `load` strobe. On that strobe the slave latches its received word and rewinds its transmit bit pointer. The block sits between the system-clocked control logic and the SPI pins/slave instance. Everything runs on `clk`; `sclk` is a divided, registered output.

---
 rtl/spi_master_if.sv | 25 ++
 rtl/spi_master.sv | 151 +++++++++++++++
 tb/tb_spi_master.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// Bus between spi_master and the logic around it: the start/done handshake,
// the parallel words, and the SPI pins going to the slave shift block.
interface spi_master_if #(
  parameter int M = 32
);
  logic         start;
  logic [M-1:0] tx_data;
  logic [M-1:0] rx_data;
  logic         busy;
  logic         done;
  logic         sclk;
  logic         mosi;
  logic         miso;
  logic         load;

  modport master (
    input  start, tx_data, miso,
    output rx_data, busy, done, sclk, mosi, load
  );

  modport slave (
    output start, tx_data, miso,
    input  rx_data, busy, done, sclk, mosi, load
  );
endinterface

// File: rtl/spi_master.sv
// SPI master: MSB-first frames of M bits, sclk half-period DIV clk cycles, load strobe at frame end.
// Define SPI_MASTER_INIT_LOAD_EN to issue a load strobe after reset so the slave starts aligned.
module spi_master #(
  parameter int M   = 32,
  parameter int DIV = 2
) (
  input  logic         clk,
  input  logic         clr,
  spi_master_if.master bus
);
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_SHIFT, S_LOAD} state_e;

  localparam int CW = $clog2(2 * DIV + 1);
  localparam int BW = $clog2(M);

  localparam logic [CW-1:0] HALF_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] DONE_PRE  = CW'(2 * DIV - 2);
  localparam logic [CW-1:0] LOAD_LAST = CW'(2 * DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(M - 1);

`ifdef SPI_MASTER_INIT_LOAD_EN
  localparam logic [CW-1:0] INIT_LAST   = CW'(2 * DIV);
  localparam state_e        RESET_STATE = S_INIT;
`else
  localparam state_e        RESET_STATE = S_IDLE;
`endif

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [M-1:0]   tx_sr_q, tx_sr_d;
  logic [M-1:0]   rx_sr_q, rx_sr_d;
  logic [M-1:0]   rx_data_q, rx_data_d;
  logic           sclk_q, sclk_d;
  logic           mosi_q, mosi_d;
  logic           load_q, load_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    load_d    = load_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
`ifdef SPI_MASTER_INIT_LOAD_EN
      S_INIT: begin
        cnt_d  = cnt_q + CW'(1);
        busy_d = 1'b1;
        load_d = (cnt_q <= HALF_LAST);
        if (cnt_q == INIT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          load_d  = 1'b0;
        end
      end
`endif
      S_IDLE: begin
        busy_d = 1'b0;
        load_d = 1'b0;
        sclk_d = 1'b0;
        if (bus.start) begin
          state_d   = S_SHIFT;
          busy_d    = 1'b1;
          tx_sr_d   = bus.tx_data;
          mosi_d    = bus.tx_data[M-1];
          cnt_d     = '0;
          bit_cnt_d = '0;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == HALF_LAST) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          // Sample on the rising half, advance mosi on every falling half but the last.
          if (!sclk_q) begin
            rx_sr_d = {rx_sr_q[M-2:0], bus.miso};
          end else if (bit_cnt_q == BIT_LAST) begin
            state_d = S_LOAD;
            load_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            tx_sr_d   = tx_sr_q << 1;
            mosi_d    = tx_sr_q[M-2];
          end
        end
      end
      S_LOAD: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == HALF_LAST) load_d = 1'b0;
        if (cnt_q == DONE_PRE) begin
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
        end
        if (cnt_q == LOAD_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= RESET_STATE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      load_q    <= load_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.load    = load_q;
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master (M=8, DIV=2) with a behavioural SPI slave and a done-driven scoreboard.
// Works with and without SPI_MASTER_INIT_LOAD_EN.
`timescale 1ns/1ps
module tb_spi_master;
  localparam int M         = 8;
  localparam int DIV       = 2;
  localparam int FRAME_CYC = 2 * DIV * M + 2 * DIV;
  localparam int BUDGET    = 200;
`ifdef SPI_MASTER_INIT_LOAD_EN
  localparam int INIT_PULSES = 1;
`else
  localparam int INIT_PULSES = 0;
`endif

  typedef struct {
    logic [7:0] tx;
    logic [7:0] di;
    logic [7:0] exp_slave;
    logic [7:0] exp_rx;
  } vec_t;

  typedef struct {
    logic [7:0] exp_slave;
    logic [7:0] exp_rx;
    bit         valid;
  } sb_t;

  logic clk = 1'b0;
  logic clr;

  spi_master_if #(.M(M)) bus ();
  spi_master #(.M(M), .DIV(DIV)) dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  int   n_checks    = 0;
  int   n_errors    = 0;
  int   load_pulses = 0;
  int   done_cnt    = 0;
  int   load_w      = 0;
  logic load_prev   = 1'b0;
  sb_t  sb[$];

  // Slave: samples mosi on rising sclk, shifts miso on falling sclk, load latches and rewinds.
  logic [7:0] s_di  = 8'h00;
  logic [7:0] s_rx  = 8'h00;
  logic [7:0] s_got = 8'h00;
  logic [2:0] s_ptr = 3'd3;

  assign bus.miso = s_di[s_ptr];

  always @(posedge bus.sclk) s_rx <= {s_rx[6:0], bus.mosi};

  always @(negedge bus.sclk or posedge bus.load) begin
    if (bus.load === 1'b1) s_ptr <= 3'd7;
    else                   s_ptr <= s_ptr - 3'd1;
  end

  always @(posedge bus.load) s_got <= s_rx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Load pulse width/count monitor and scoreboard drain on done.
  always @(negedge clk) begin
    sb_t e;
    if (bus.load === 1'b1 && load_prev !== 1'b1) load_pulses++;
    if (bus.load === 1'b1) begin
      load_w++;
    end else begin
      if (load_prev === 1'b1) check("load_width", 32'(load_w), 32'(DIV));
      load_w = 0;
    end
    load_prev = bus.load;
    if (bus.done === 1'b1) begin
      done_cnt++;
      check("done_has_expect", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.valid) begin
          check("rx_data", 32'(bus.rx_data), 32'(e.exp_rx));
          check("slave_rx", 32'(s_got), 32'(e.exp_slave));
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_sclk"},    32'(bus.sclk),    32'(0));
    check({tag, "_mosi"},    32'(bus.mosi),    32'(0));
    check({tag, "_load"},    32'(bus.load),    32'(0));
    check({tag, "_busy"},    32'(bus.busy),    32'(0));
    check({tag, "_done"},    32'(bus.done),    32'(0));
    check({tag, "_rx_data"}, 32'(bus.rx_data), 32'(0));
  endtask

  task automatic release_reset();
    clr = 1'b0;
    for (int k = 1; k <= 2 * DIV + 1; k++) begin
      tick();
`ifdef SPI_MASTER_INIT_LOAD_EN
      check("init_load", 32'(bus.load), 32'(k <= DIV));
      check("init_busy", 32'(bus.busy), 32'(k <= 2 * DIV));
`else
      check("init_load", 32'(bus.load), 32'(0));
      check("init_busy", 32'(bus.busy), 32'(0));
`endif
    end
  endtask

  task automatic run_frame(input vec_t v, input bit valid, input bit noise,
                           output int done_cyc, output int rises, output int first_rise);
    sb_t  e;
    logic prev_sclk;
    bit   busy_ok;
    s_di        = v.di;
    bus.tx_data = v.tx;
    bus.start   = 1'b1;
    e.exp_slave = v.exp_slave;
    e.exp_rx    = v.exp_rx;
    e.valid     = valid;
    sb.push_back(e);
    done_cyc   = -1;
    rises      = 0;
    first_rise = -1;
    busy_ok    = 1'b1;
    prev_sclk  = bus.sclk;
    for (int c = 1; c <= BUDGET; c++) begin
      tick();
      bus.start = 1'b0;
      if (noise) begin
        if (c == 3) bus.tx_data = ~v.tx;
        if (c == 5 || c == 20) begin
          bus.start   = 1'b1;
          bus.tx_data = 8'($urandom);
        end
      end
      if (c == 1) check("mosi_first_bit", 32'(bus.mosi), 32'(v.tx[7]));
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.sclk === 1'b1 && prev_sclk !== 1'b1) begin
        rises++;
        if (first_rise < 0) first_rise = c;
      end
      prev_sclk = bus.sclk;
      if (bus.done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
    check("frame_done_seen", 32'(done_cyc > 0), 32'(1));
    check("busy_through_frame", 32'(busy_ok), 32'(1));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   dc, rises, fr, lp0, dcnt0;
`ifndef SPI_MASTER_INIT_LOAD_EN
    vec_t warm;
    warm = '{8'h00, 8'h00, 8'h00, 8'h00};
`endif
    vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{8'h01, 8'hFF, 8'h01, 8'hFF};
    vecs[2] = '{8'h80, 8'h00, 8'h80, 8'h00};
    vecs[3] = '{8'h3C, 8'hA5, 8'h3C, 8'hA5};
    vecs[4] = '{8'h96, 8'h69, 8'h96, 8'h69};

    bus.start   = 1'b0;
    bus.tx_data = 8'h00;
    clr         = 1'b1;
    repeat (3) tick();
    check_reset_values("reset");
    release_reset();
    check("init_pulses", 32'(load_pulses), 32'(INIT_PULSES));

`ifndef SPI_MASTER_INIT_LOAD_EN
    // Slave pointer is unaligned until the first load; this frame only realigns it.
    run_frame(warm, 1'b0, 1'b0, dc, rises, fr);
    tick();
`endif

    // Table frames, each started on the cycle after the previous done.
    lp0 = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) lp0 = load_pulses;
      run_frame(vecs[i], 1'b1, 1'b0, dc, rises, fr);
      check("done_cycle", 32'(dc), 32'(FRAME_CYC));
      check("sclk_rises", 32'(rises), 32'(M));
      check("first_rise", 32'(fr), 32'(1 + DIV));
      if (i == 2) check("b2b_load_pulses", 32'(load_pulses - lp0), 32'(2));
      tick();
    end

    // Start pulses and tx_data changes mid-frame must be ignored.
    dcnt0 = done_cnt;
    run_frame('{8'hC6, 8'h39, 8'hC6, 8'h39}, 1'b1, 1'b1, dc, rises, fr);
    check("noise_done_cycle", 32'(dc), 32'(FRAME_CYC));
    repeat (2 * DIV * (M + 1) + 4) tick();
    check("noise_single_done", 32'(done_cnt - dcnt0), 32'(1));
    check("noise_idle_after", 32'(bus.busy), 32'(0));

    // Abort at cycle 15: nothing pushed, so any done would be flagged.
    lp0         = load_pulses;
    s_di        = 8'h0F;
    bus.tx_data = 8'hF0;
    bus.start   = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      bus.start = 1'b0;
    end
    clr = 1'b1;
    tick();
    check_reset_values("abort");
    check("abort_no_load", 32'(load_pulses - lp0), 32'(0));
    release_reset();
    check("abort_init_pulses", 32'(load_pulses - lp0), 32'(INIT_PULSES));
`ifndef SPI_MASTER_INIT_LOAD_EN
    run_frame(warm, 1'b0, 1'b0, dc, rises, fr);
    tick();
`endif
    run_frame('{8'h5A, 8'hC3, 8'h5A, 8'hC3}, 1'b1, 1'b0, dc, rises, fr);
    check("post_abort_done_cycle", 32'(dc), 32'(FRAME_CYC));
    repeat (5) tick();
    check("sb_drained", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
